// File: rtl/mem_responder.sv
// Dual-port (imem/dmem) memory responder: round-robin arbitration onto a single
// word-addressed array, with one registered response per accepted request.
module mem_responder #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imemreq_val,
  output logic              imemreq_rdy,
  input  logic [ADDR_W-1:0] imemreq_addr,
  output logic              imemresp_val,
  input  logic              imemresp_rdy,
  output logic [DATA_W-1:0] imemresp_data,
  input  logic              dmemreq_val,
  output logic              dmemreq_rdy,
  input  logic              dmemreq_rw,
  input  logic [ADDR_W-1:0] dmemreq_addr,
  input  logic [DATA_W-1:0] dmemreq_data,
  output logic              dmemresp_val,
  input  logic              dmemresp_rdy,
  output logic [DATA_W-1:0] dmemresp_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    PRIO_IMEM,
    PRIO_DMEM
  } prio_e;

  prio_e prio_q, prio_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic i_free, d_free;
  logic i_cand, d_cand;
  logic i_acc, d_acc;

  // Byte offset and bits above the array depth are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imemreq_addr[ADDR_W-1:DEPTH_LOG2+2], imemreq_addr[1:0],
                              dmemreq_addr[ADDR_W-1:DEPTH_LOG2+2], dmemreq_addr[1:0]};

  assign i_idx = imemreq_addr[DEPTH_LOG2+1:2];
  assign d_idx = dmemreq_addr[DEPTH_LOG2+1:2];

  // A port can take a new request if its response slot is empty or drains this cycle.
  assign i_free = ~imemresp_val | imemresp_rdy;
  assign d_free = ~dmemresp_val | dmemresp_rdy;
  assign i_cand = imemreq_val & i_free;
  assign d_cand = dmemreq_val & d_free;

  // Written without the port's own val so rdy never loops back onto it.
  assign imemreq_rdy = rst & i_free & (~d_cand | (prio_q == PRIO_IMEM));
  assign dmemreq_rdy = rst & d_free & (~i_cand | (prio_q == PRIO_DMEM));

  assign i_acc = imemreq_val & imemreq_rdy;
  assign d_acc = dmemreq_val & dmemreq_rdy;

  always_comb begin
    prio_d = prio_q;
    if (i_acc && d_cand) begin
      prio_d = PRIO_DMEM;
    end else if (d_acc && i_cand) begin
      prio_d = PRIO_IMEM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= PRIO_IMEM;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Storage is intentionally not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (d_acc && dmemreq_rw) begin
      mem[d_idx] <= dmemreq_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imemresp_val  <= 1'b0;
      imemresp_data <= '0;
    end else if (i_acc) begin
      imemresp_val  <= 1'b1;
      imemresp_data <= mem[i_idx];
    end else if (imemresp_rdy) begin
      imemresp_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmemresp_val  <= 1'b0;
      dmemresp_data <= '0;
    end else if (d_acc) begin
      dmemresp_val  <= 1'b1;
      dmemresp_data <= dmemreq_rw ? '0 : mem[d_idx];
    end else if (dmemresp_rdy) begin
      dmemresp_val  <= 1'b0;
    end
  end

endmodule
